matrix_result_streamer: RTL and testbench
=========================================

Name: matrix_result_streamer

Overview:
Consumer end of the 10x10 matrix multiplier. It snapshots the flat 16-bit-per-element result bus when the multiplier's done flag rises. It then serialises the snapshot as a byte stream over a valid/ready handshake, for a UART transmitter or host link. Elements are sent in row-major order, MSB byte first, with a last-byte marker and a frame-complete pulse.

Parameters:
N, 10, matrix dimension; the frame holds N*N elements.
ELEM_W, 16, result element width in bits; must be a multiple of 8.
BPE, ELEM_W/8, bytes per element (derived, not overridable).
FRAME_BYTES, N*N*BPE, bytes per frame (200 at defaults; derived).

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
mult_done  in  1  multiplier done flag; level signal that may stay high indefinitely
result  in  N*N*ELEM_W  flat result bus; element e = result[e*ELEM_W +: ELEM_W], e = row*N + col
out_data  out  8  current byte
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the byte when out_valid && out_ready
out_last  out  1  high with the final byte of a frame
busy  out  1  high while a frame is being sent
frame_done  out  1  one-cycle pulse after the final byte is accepted
overrun  out  1  sticky; set when a new result arrives during a frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0, snapshot 0, done_q=0.
- Outputs on reset: out_valid=0, out_last=0, busy=0, frame_done=0, overrun=0, out_data=0.
- Reset asserted mid-frame aborts the frame immediately. No partial completion, no frame_done.
- Rise detection: rise = mult_done && !done_q; done_q <= mult_done every cycle.
  - A mult_done that is already high when rst_n releases counts as a rise on the first clock.
  - mult_done held high produces exactly one rise.
- States: IDLE, SEND, DONE.
- IDLE:
  - On rise: snapshot <= result, byte_idx <= 0, go to SEND.
  - out_valid goes high on the cycle after the rise edge, so first-byte latency is 1 cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_data = byte (BPE-1 - byte_idx mod BPE) of element byte_idx/BPE. High byte goes first.
  - out_last = (byte_idx == FRAME_BYTES-1).
  - Handshake: advance byte_idx only when out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - Accepting the last byte moves to DONE.
- DONE:
  - One cycle only. frame_done=1, out_valid=0, busy=0.
  - Then go to IDLE.
- Rise while in SEND or DONE:
  - overrun <= 1, which is sticky until reset.
  - The snapshot is not altered and no new frame is queued.
- Rise in the same cycle that DONE returns to IDLE is lost and sets overrun.
- Minimum frame time is FRAME_BYTES+2 cycles with out_ready held high (rise edge, 200 SEND cycles, DONE).
- Counter: byte_idx is $clog2(FRAME_BYTES) bits wide (8 at defaults) and never wraps past FRAME_BYTES-1.
- Byte selection uses element index = byte_idx/BPE and byte-within-element = byte_idx%BPE. The two may be held as separate elem_idx/sub_idx counters provided the results are identical.

Decomposition:
- Shared package holds:
  - constants N, ELEM_W, BPE, FRAME_BYTES and IDX_W = $clog2(FRAME_BYTES);
  - the state enum {IDLE, SEND, DONE}.
- The same package is reused by the multiplier and future loader blocks.
- One natural sub-module: rise_detect (1-bit registered edge detector with async active-low reset), instantiated on mult_done.

Test Plan:
- Reset state: hold rst_n=0 with mult_done=1 -> all outputs 0. Release -> out_valid=1 at the second clock after release.
- Full frame, out_ready=1: result element0=0x1234, element99=0xBEEF, element e=e otherwise.
  - Bytes 0,1 = 0x12,0x34; bytes 2,3 = 0x00,0x01.
  - Bytes 198,199 = 0xBE,0xEF, with out_last=1 only on byte 199.
  - frame_done pulses exactly one cycle later; 200 handshakes total.
- Backpressure: drop out_ready for 5 cycles at byte 37 -> out_data, out_last and out_valid stay constant. No byte is skipped or duplicated.
- Level done: keep mult_done high for 1000 cycles -> exactly one frame; overrun stays 0.
- Overrun: pulse mult_done low then high at byte 50 -> frame continues from the original snapshot and overrun=1. No second frame follows.
- Mid-frame reset: assert rst_n=0 at byte 100 -> out_valid and busy drop asynchronously. With mult_done still high after release, a fresh frame starts from byte 0.

Source files
------------

// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants and FSM encoding for the matrix multiplier slice.
// Used by the multiplier, result streamer and loader blocks.
package matrix_result_streamer_pkg;

  localparam int N           = 10;
  localparam int ELEM_W      = 16;
  localparam int BPE         = ELEM_W / 8;
  localparam int FRAME_BYTES = N * N * BPE;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam int SNAP_W      = N * N * ELEM_W;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] BPE_IDX =
    IDX_W'(BPE);
  localparam logic [IDX_W-1:0] BPE_M1 =
    IDX_W'(BPE - 1);

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Byte stream valid/ready bundle.
// master drives data/valid/last, slave drives ready.
interface matrix_result_streamer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_result_streamer_rise_detect.sv
// Registered rising-edge detector; async active-low reset.
// Ports: clk, rst_n, d (level in), rise (d high, was low).
module matrix_result_streamer_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots the multiplier result on done and streams it as bytes.
// Ports: clk, rst_n, mult_done, result, stream(master), busy, frame_done, overrun.
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mult_done,
  input  logic [SNAP_W-1:0]     result,
  matrix_result_streamer_if.master stream,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  state_t             state;
  logic [IDX_W-1:0]   byte_idx;
  logic [SNAP_W-1:0]  snapshot;
  logic               rise;
  logic [IDX_W-1:0]   sub;
  logic [IDX_W-1:0]   fb;
  logic               sending;
  logic               accept;
  logic               at_last;

  matrix_result_streamer_rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mult_done),
    .rise (rise)
  );

  assign sending = (state == SEND);
  assign at_last = (byte_idx == LAST_IDX);
  assign accept  = sending & stream.out_ready;

  // Element bytes sit LSB-first in the flat bus,
  // but go out MSB-first: mirror the sub-index.
  always_comb begin
    sub = byte_idx % BPE_IDX;
    fb  = byte_idx - sub + (BPE_M1 - sub);
  end

  assign stream.out_valid = sending;
  assign stream.out_last  = sending & at_last;
  assign stream.out_data  =
    sending ? snapshot[{fb, 3'b000} +: 8] : 8'h00;

  assign busy       = sending;
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= '0;
      snapshot <= '0;
      overrun  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            snapshot <= result;
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (rise) overrun <= 1'b1;
          if (accept) begin
            if (at_last) state <= DONE;
            else byte_idx <= byte_idx + 1'b1;
          end
        end
        DONE: begin
          if (rise) overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed self-checking bench for matrix_result_streamer.
// Covers reset, full frame, backpressure, level done, overrun, mid-frame reset.
module tb_matrix_result_streamer;
  import matrix_result_streamer_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mult_done;
  logic [SNAP_W-1:0] result;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int compared   = 0;
  int mismatched = 0;

  matrix_result_streamer_if s ();

  matrix_result_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mult_done (mult_done),
    .result    (result),
    .stream    (s),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] elem_val(int e);
    if (e == 0)  return 16'h1234;
    if (e == 99) return 16'hBEEF;
    return 16'(e);
  endfunction

  function automatic logic [7:0] exp_byte(int k);
    logic [15:0] v;
    case (k)
      0:   return 8'h12;
      1:   return 8'h34;
      2:   return 8'h00;
      3:   return 8'h01;
      198: return 8'hBE;
      199: return 8'hEF;
      default: begin
        v = elem_val(k / 2);
        return (k % 2 == 0) ? v[15:8] : v[7:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_model();
    for (int e = 0; e < N * N; e++)
      result[e*ELEM_W +: ELEM_W] = elem_val(e);
  endtask

  // Receives one frame starting at the current sample point.
  task automatic recv_frame(input int stall_at,
                            input int ovr_at);
    int k = 0;
    int cyc = 0;
    logic [7:0] d0;
    logic       l0;
    while (k < FRAME_BYTES && cyc < 3000) begin
      cyc++;
      if (!s.out_valid) begin
        step();
        continue;
      end
      if (k == stall_at) begin
        s.out_ready = 1'b0;
        d0 = s.out_data;
        l0 = s.out_last;
        repeat (5) begin
          step();
          chk("stall_valid", 32'(s.out_valid), 32'd1);
          chk("stall_data", 32'(s.out_data), 32'(d0));
          chk("stall_last", 32'(s.out_last), 32'(l0));
        end
        s.out_ready = 1'b1;
      end
      if (k == ovr_at) begin
        mult_done = 1'b0;
        result = '1;
      end else if (k == ovr_at + 1) begin
        mult_done = 1'b1;
      end
      chk($sformatf("data[%0d]", k),
          32'(s.out_data), 32'(exp_byte(k)));
      chk($sformatf("last[%0d]", k),
          32'(s.out_last),
          32'(k == FRAME_BYTES - 1));
      k++;
      step();
    end
    chk("handshakes", 32'(k), 32'(FRAME_BYTES));
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_valid", 32'(s.out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    step();
    chk("done_once", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic quiet(input int cycles,
                       input string tag);
    int act = 0;
    repeat (cycles) begin
      step();
      if (s.out_valid || frame_done) act++;
    end
    chk(tag, 32'(act), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mult_done   = 1'b1;
    s.out_ready = 1'b1;
    load_model();
    repeat (3) step();
    chk("rst_valid", 32'(s.out_valid), 32'd0);
    chk("rst_last", 32'(s.out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(s.out_data), 32'd0);

    rst_n = 1'b1;
    chk("pre_rise_valid", 32'(s.out_valid), 32'd0);
    step();
    chk("first_valid", 32'(s.out_valid), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);

    recv_frame(37, -1);
    chk("frame1_ovr", 32'(overrun), 32'd0);

    quiet(1000, "level_done_frames");
    chk("level_ovr", 32'(overrun), 32'd0);

    mult_done = 1'b0;
    step();
    mult_done = 1'b1;
    step();
    recv_frame(-1, 50);
    chk("ovr_set", 32'(overrun), 32'd1);
    quiet(300, "ovr_no_frame");
    chk("ovr_sticky", 32'(overrun), 32'd1);

    load_model();
    mult_done = 1'b0;
    step();
    mult_done = 1'b1;
    step();
    repeat (100) step();
    chk("pre_abort_data", 32'(s.out_data),
        32'(exp_byte(100)));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(s.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(frame_done), 32'd0);
    chk("abort_ovr", 32'(overrun), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("restart_valid", 32'(s.out_valid), 32'd1);
    recv_frame(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
